// File: rtl/load_rr_arbiter_pkg.sv
// Shared definitions for the load_rr_arbiter block: FSM state encoding,
// winner-index width and cooldown counter width.
package load_rr_arbiter_pkg;

  // Width of gnt_id / round-robin pointer (covers up to 8 requesters).
  localparam int GNT_W = 3;

  // Width of the cooldown counter (covers HOLD up to 15).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_COOL  = 2'd2
  } state_t;

endpackage

// File: rtl/load_rr_arbiter_rr_pick.sv
// Combinational round-robin priority picker: returns the first set request
// bit found scanning ptr, ptr+1, ..., N-1, 0, ... with wrap-around.
module load_rr_arbiter_rr_pick
  import load_rr_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [GNT_W-1:0] ptr,
  output logic [GNT_W-1:0] idx,
  output logic             valid
);

  logic [N-1:0] rot;

  // Rotate requests so bit 0 is the current top-priority requester, then
  // take the lowest set bit (loop runs high-to-low so the lowest wins).
  always_comb begin
    int pos;
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    rot   = N'({req, req} >> ptr);
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pos = int'(ptr) + k;
        if (pos >= N) pos = pos - N;
        idx   = GNT_W'(pos);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/load_rr_arbiter.sv
// Round-robin arbiter sharing one external parallel-load register between
// N requesters: one load (L/D) per grant, a one-cycle ack to the winner, then
// HOLD cooldown cycles before the next arbitration.
// Optional build macro: LOAD_RR_ARB_STATS_EN adds the saturating load_cnt
// output counting completed grants.
module load_rr_arbiter
  import load_rr_arbiter_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 4,
  parameter int HOLD = 1
) (
  input  logic             C,
  input  logic             aRn,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   din,
  output logic             L,
  output logic [W-1:0]     D,
  output logic [N-1:0]     ack,
  output logic [GNT_W-1:0] gnt_id,
  output logic             busy
`ifdef LOAD_RR_ARB_STATS_EN
  ,
  output logic [7:0]       load_cnt
`endif
);

  localparam logic [GNT_W-1:0] LAST_ID = GNT_W'(N - 1);
  localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [N-1:0]     ONE_N   = N'(1);

  state_t           state_q, state_d;
  logic [GNT_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             l_d;
  logic [W-1:0]     d_d;
  logic [N-1:0]     ack_d;
  logic [GNT_W-1:0] gnt_d;
  logic [GNT_W-1:0] pick_idx;
  logic             pick_valid;

  load_rr_arbiter_rr_pick #(.N(N)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Next-state and next-output logic; L/ack/D/gnt_id are computed here and
  // registered so they reach the shared register glitch-free.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    l_d     = 1'b0;
    ack_d   = '0;
    d_d     = D;
    gnt_d   = gnt_id;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          l_d     = 1'b1;
          ack_d   = ONE_N << pick_idx;
          d_d     = W'(din >> (int'(pick_idx) * W));
          gnt_d   = pick_idx;
        end
      end
      ST_GRANT: begin
        // Winner's successor becomes top priority for the next arbitration.
        ptr_d = (gnt_id == LAST_ID) ? '0 : gnt_id + GNT_W'(1);
        if (HOLD > 0) begin
          state_d = ST_COOL;
          cnt_d   = HOLD_C;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COOL: begin
        // Leaving when the count reaches 1 gives exactly HOLD cooldown cycles.
        if (cnt_q <= CNT_ONE) state_d = ST_IDLE;
        else                  cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any transfer in flight.
  always_ff @(posedge C or negedge aRn) begin
    if (!aRn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      L       <= 1'b0;
      D       <= '0;
      ack     <= '0;
      gnt_id  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      L       <= l_d;
      D       <= d_d;
      ack     <= ack_d;
      gnt_id  <= gnt_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

`ifdef LOAD_RR_ARB_STATS_EN
  // Count completed GRANT cycles, saturating at 255.
  always_ff @(posedge C or negedge aRn) begin
    if (!aRn) begin
      load_cnt <= 8'd0;
    end else if (state_q == ST_GRANT && load_cnt != 8'hFF) begin
      load_cnt <= load_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_load_rr_arbiter.sv
// Scoreboard bench for load_rr_arbiter: the driver applies directed and
// random requests and a reference model pushes expected loads into a queue;
// an independent monitor pops and compares whenever L is seen.
module tb_load_rr_arbiter;

  localparam int N    = 4;
  localparam int W    = 4;
  localparam int HOLD = 1;

  logic           C   = 1'b0;
  logic           aRn = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] din = '0;
  logic           L;
  logic [W-1:0]   D;
  logic [N-1:0]   ack;
  logic [2:0]     gnt_id;
  logic           busy;
`ifdef LOAD_RR_ARB_STATS_EN
  logic [7:0]     load_cnt;
`endif

  load_rr_arbiter #(.N(N), .W(W), .HOLD(HOLD)) dut (
    .C      (C),
    .aRn    (aRn),
    .req    (req),
    .din    (din),
    .L      (L),
    .D      (D),
    .ack    (ack),
    .gnt_id (gnt_id),
`ifdef LOAD_RR_ARB_STATS_EN
    .load_cnt (load_cnt),
`endif
    .busy   (busy)
  );

  always #5 C = ~C;

  typedef struct {
    int         edge_no;
    int         id;
    logic [W-1:0] data;
  } load_t;

  load_t exp_q[$];
  load_t obs_q[$];

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  // Reference model state (spec-level: earliest decision edge, pointer, last load).
  int           ready_at  = 0;
  int           last_dec  = -1000;
  int           mptr      = 0;
  int           raw_loads = 0;
  int           last_id   = 0;
  logic [W-1:0] last_d    = '0;
  logic [N-1:0] pend      = '0;

  always @(posedge C) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    ready_at  = 0;
    last_dec  = -1000;
    mptr      = 0;
    raw_loads = 0;
    last_id   = 0;
    last_d    = '0;
  endtask

  // Decide what the arbiter must do at the coming edge from the current inputs.
  task automatic model_decide();
    int e;
    int win;
    logic [N-1:0]   rb;
    logic [N*W-1:0] sh;
    load_t x;
    e   = edge_cnt + 1;
    win = -1;
    if (aRn && e >= ready_at && req != '0) begin
      for (int k = 0; k < N; k++) begin
        rb = req >> ((mptr + k) % N);
        if (win < 0 && rb[0]) win = (mptr + k) % N;
      end
      sh        = din >> (win * W);
      x.edge_no = e;
      x.id      = win;
      x.data    = sh[W-1:0];
      exp_q.push_back(x);
      last_d    = x.data;
      last_id   = win;
      last_dec  = e;
      ready_at  = e + HOLD + 2;
      mptr      = (win + 1) % N;
      raw_loads++;
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] d);
    @(negedge C);
    req = r;
    din = d;
    model_decide();
  endtask

  task automatic after_edge();
    @(posedge C);
    #2;
  endtask

  task automatic pulse_reset();
    @(negedge C);
    req = '0;
    aRn = 1'b0;
    model_reset();
    @(negedge C);
    aRn = 1'b1;
  endtask

  task automatic run_until(input int n, input logic [N-1:0] r, input logic [N*W-1:0] d,
                           input int budget, input string name);
    int k;
    k = 0;
    while (obs_q.size() < n && k < budget) begin
      step(r, d);
      k++;
    end
    check(name, 32'(obs_q.size() >= n), 32'd1);
  endtask

  // Monitor: compares every cycle, popping the scoreboard on each L pulse.
  initial begin
    load_t x;
    load_t o;
    int    ld;
    forever begin
      @(posedge C);
      #1;
      if (L) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_L: got gnt_id=%0d D=%0h expected no load (edge %0d)", gnt_id, D, edge_cnt);
        end else begin
          x = exp_q.pop_front();
          check("l_edge", edge_cnt, x.edge_no);
          check("l_id", 32'(gnt_id), x.id);
          check("l_data", 32'(D), 32'(x.data));
          check("l_ack", 32'(ack), 32'(1) << x.id);
        end
        o.edge_no = edge_cnt;
        o.id      = int'(gnt_id);
        o.data    = D;
        obs_q.push_back(o);
      end else begin
        check("ack_idle", 32'(ack), 32'd0);
        if (exp_q.size() != 0 && exp_q[0].edge_no <= edge_cnt) begin
          checks++;
          failures++;
          $display("FAIL missing_L: got L=0 expected load id=%0d at edge %0d", exp_q[0].id, exp_q[0].edge_no);
          void'(exp_q.pop_front());
        end
      end
      check("busy", 32'(busy), 32'((last_dec <= edge_cnt) && (edge_cnt <= last_dec + HOLD)));
      check("d_hold", 32'(D), 32'(last_d));
      check("gnt_id", 32'(gnt_id), last_id);
`ifdef LOAD_RR_ARB_STATS_EN
      ld = raw_loads - ((last_dec == edge_cnt) ? 1 : 0);
      if (ld > 255) ld = 255;
      check("load_cnt", 32'(load_cnt), ld);
`else
      ld = 0;
`endif
    end
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ids[5];
    int exp_dat[5];
    logic [N-1:0] nb;
    exp_ids = '{0, 1, 2, 3, 0};
    exp_dat = '{1, 2, 3, 4, 1};

    // 1. Reset state, then idle for 10 cycles.
    repeat (2) @(negedge C);
    check("rst_L", 32'(L), 32'd0);
    check("rst_D", 32'(D), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", 32'(gnt_id), 32'd0);
    @(negedge C);
    aRn = 1'b1;
    repeat (10) step('0, '0);
    check("idle_L", 32'(L), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // 2. Single request from requester 2 with data A.
    step(4'b0100, 16'h0A00);
    after_edge();
    check("t2_L", 32'(L), 32'd1);
    check("t2_D", 32'(D), 32'hA);
    check("t2_ack", 32'(ack), 32'b0100);
    check("t2_gnt", 32'(gnt_id), 32'd2);
    check("t2_busy_g", 32'(busy), 32'd1);
    step('0, 16'h0A00);
    after_edge();
    check("t2_busy_c", 32'(busy), 32'd1);
    check("t2_L_c", 32'(L), 32'd0);
    after_edge();
    check("t2_busy_end", 32'(busy), 32'd0);

    // 3. All requesting: fair order, fixed spacing, data sequence.
    pulse_reset();
    obs_q.delete();
    run_until(5, 4'b1111, 16'h4321, 40, "t3_timeout");
    for (int i = 0; i < 5; i++) begin
      if (i < obs_q.size()) begin
        check("t3_order", obs_q[i].id, exp_ids[i]);
        check("t3_data", 32'(obs_q[i].data), exp_dat[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (i + 1 < obs_q.size())
        check("t3_spacing", obs_q[i+1].edge_no - obs_q[i].edge_no, HOLD + 2);
    end
    repeat (HOLD + 3) step('0, '0);

    // 4. Pointer wrap: grant 3, then 1001 -> 0 then 3.
    pulse_reset();
    obs_q.delete();
    run_until(1, 4'b1000, 16'h5000, 10, "t4a_timeout");
    obs_q.delete();
    run_until(2, 4'b1001, 16'h5006, 20, "t4b_timeout");
    if (obs_q.size() >= 2) begin
      check("t4_first", obs_q[0].id, 0);
      check("t4_second", obs_q[1].id, 3);
    end
    repeat (HOLD + 3) step('0, '0);

    // 5a. Reset during COOL, then requester 1 wins after release.
    step(4'b0100, 16'h0300);
    step('0, 16'h0300);
    @(negedge C);
    check("t5c_pre_busy", 32'(busy), 32'd1);
    aRn = 1'b0;
    model_reset();
    #1;
    check("t5c_L", 32'(L), 32'd0);
    check("t5c_busy", 32'(busy), 32'd0);
    check("t5c_D", 32'(D), 32'd0);
    check("t5c_gnt", 32'(gnt_id), 32'd0);
    @(negedge C);
    aRn = 1'b1;
    obs_q.delete();
    req = 4'b0010;
    din = 16'h00B0;
    model_decide();
    run_until(1, 4'b0010, 16'h00B0, 10, "t5c_timeout");
    if (obs_q.size() >= 1) check("t5c_win", obs_q[0].id, 1);
    repeat (HOLD + 3) step('0, '0);

    // 5b. Reset during GRANT.
    step(4'b0100, 16'h0700);
    @(posedge C);
    #2;
    check("t5g_pre_L", 32'(L), 32'd1);
    #1;
    aRn = 1'b0;
    model_reset();
    #1;
    check("t5g_L", 32'(L), 32'd0);
    check("t5g_ack", 32'(ack), 32'd0);
    check("t5g_busy", 32'(busy), 32'd0);
    @(negedge C);
    aRn = 1'b1;
    obs_q.delete();
    req = 4'b0010;
    din = 16'h00C0;
    model_decide();
    run_until(1, 4'b0010, 16'h00C0, 10, "t5g_timeout");
    if (obs_q.size() >= 1) check("t5g_win", obs_q[0].id, 1);
    repeat (HOLD + 3) step('0, '0);

    // 6. Request pulsed only during COOL is not granted.
    pulse_reset();
    obs_q.delete();
    step(4'b0100, 16'h0900);
    step('0, 16'h0900);
    step(4'b0010, 16'h0090);
    repeat (6) step('0, '0);
    check("t6_loads", obs_q.size(), 1);
`ifdef LOAD_RR_ARB_STATS_EN
    check("t6_cnt", 32'(load_cnt), 32'd1);
`endif

    // Long all-request run: load_cnt saturates when the stats build is used.
    pulse_reset();
    obs_q.delete();
    run_until(300, 4'b1111, 16'h8421, 1000, "sat_timeout");
    repeat (HOLD + 3) step('0, '0);
`ifdef LOAD_RR_ARB_STATS_EN
    check("sat_cnt", 32'(load_cnt), 32'd255);
`endif

    // Random requesters: hold until granted, occasional withdrawal.
    pulse_reset();
    pend = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        nb   = N'($urandom_range(0, (1 << N) - 1));
        pend = pend | nb;
      end
      if ($urandom_range(0, 9) == 0) pend = pend & ~(N'(1) << $urandom_range(0, N - 1));
      step(pend, (N*W)'($urandom));
      if (last_dec == edge_cnt + 1) pend = pend & ~(N'(1) << last_id);
    end
    repeat (HOLD + 4) step('0, '0);
    check("drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
